// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for a CR16-style datapath.
// Sequences fetch/decode/execute and drives every datapath enable from registered outputs.
module multicycle_ctrl #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4,
  parameter int FLAG_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                mem_valid,
  input  logic [FLAG_W-1:0]   flags,
  output logic [DATA_W-1:0]   instr,
  output logic [SEL_W-1:0]    mux_a_sel,
  output logic [SEL_W-1:0]    mux_b_sel,
  output logic [NUM_REGS-1:0] reg_en,
  output logic                wb_sel,
  output logic                imm_sel,
  output logic                flag_en,
  output logic                addr_sel,
  output logic                mem_we,
  output logic                pc_inc,
  output logic                pc_ld,
  output logic                pc_src
);

  typedef enum logic [2:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC,
    ST_MEM_RD, ST_LOAD_WB, ST_MEM_WR, ST_BRANCH
  } state_t;

  localparam logic [3:0] OP_RR    = 4'h0;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] EXT_LOAD = 4'h0;
  localparam logic [3:0] EXT_STOR = 4'h4;
  localparam logic [3:0] EXT_CMP  = 4'hB;
  localparam logic [3:0] EXT_JMP  = 4'hC;

  state_t              state_r, state_nxt_s;
  logic [DATA_W-1:0]   instr_r, instr_nxt_s;
  logic [SEL_W-1:0]    mux_a_sel_r, mux_b_sel_r;
  logic [NUM_REGS-1:0] reg_en_r, reg_en_nxt_s;
  logic wb_sel_r, imm_sel_r, flag_en_r, addr_sel_r, mem_we_r, pc_inc_r, pc_ld_r, pc_src_r;
  logic wb_sel_nxt_s, imm_sel_nxt_s, flag_en_nxt_s, addr_sel_nxt_s;
  logic mem_we_nxt_s, pc_inc_nxt_s, pc_ld_nxt_s, pc_src_nxt_s;

  logic [3:0] cur_op_s, cur_ext_s, nxt_op_s, nxt_ext_s, nxt_cond_s;
  logic [SEL_W-1:0] nxt_rdest_s;

  // Out-of-range register selects produce no write enable at all.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_REGS-1:0] vec;
    vec = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(sel) == i) begin
        vec[i] = 1'b1;
      end else begin
        vec[i] = 1'b0;
      end
    end
    return vec;
  endfunction

  // Flag order is {N,Z,F,L,C}.
  function automatic logic cond_true(input logic [3:0] cond, input logic [FLAG_W-1:0] f);
    logic n, z, fl, l, c;
    n = f[4]; z = f[3]; fl = f[2]; l = f[1]; c = f[0];
    case (cond)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return c;
      4'h3:    return !c;
      4'h4:    return l;
      4'h5:    return !l;
      4'h6:    return n;
      4'h7:    return !n;
      4'h8:    return fl;
      4'h9:    return !fl;
      4'hA:    return !l && !z;
      4'hB:    return l || z;
      4'hC:    return !n && !z;
      4'hD:    return n || z;
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign cur_op_s    = instr_r[15:12];
  assign cur_ext_s   = instr_r[7:4];
  assign nxt_op_s    = instr_nxt_s[15:12];
  assign nxt_ext_s   = instr_nxt_s[7:4];
  assign nxt_cond_s  = instr_nxt_s[11:8];
  assign nxt_rdest_s = instr_nxt_s[8 +: SEL_W];

  // Next state and instruction register load.
  always_comb begin
    state_nxt_s = state_r;
    instr_nxt_s = instr_r;
    case (state_r)
      ST_RESET: state_nxt_s = ST_FETCH;
      ST_FETCH: begin
        if (mem_valid) begin
          instr_nxt_s = mem_data;
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (cur_op_s == OP_BCOND) begin
          state_nxt_s = ST_BRANCH;
        end else if (cur_op_s != OP_MEM) begin
          state_nxt_s = ST_EXEC;
        end else begin
          case (cur_ext_s)
            EXT_LOAD: state_nxt_s = ST_MEM_RD;
            EXT_STOR: state_nxt_s = ST_MEM_WR;
            EXT_JMP:  state_nxt_s = ST_BRANCH;
            default:  state_nxt_s = ST_FETCH;
          endcase
        end
      end
      ST_MEM_RD: begin
        if (mem_valid) begin
          state_nxt_s = ST_LOAD_WB;
        end else begin
          state_nxt_s = ST_MEM_RD;
        end
      end
      ST_EXEC, ST_LOAD_WB, ST_MEM_WR, ST_BRANCH: state_nxt_s = ST_FETCH;
      default: state_nxt_s = ST_RESET;
    endcase
  end

  // Moore output decode of the upcoming state, captured into output registers.
  always_comb begin
    reg_en_nxt_s   = {NUM_REGS{1'b0}};
    wb_sel_nxt_s   = 1'b0;
    imm_sel_nxt_s  = 1'b0;
    flag_en_nxt_s  = 1'b0;
    addr_sel_nxt_s = 1'b0;
    mem_we_nxt_s   = 1'b0;
    pc_inc_nxt_s   = 1'b0;
    pc_ld_nxt_s    = 1'b0;
    pc_src_nxt_s   = 1'b0;
    case (state_nxt_s)
      ST_DECODE: begin
        // Undefined memory-group extensions retire as a NOP straight from decode.
        if (nxt_op_s == OP_MEM && nxt_ext_s != EXT_LOAD &&
            nxt_ext_s != EXT_STOR && nxt_ext_s != EXT_JMP) begin
          pc_inc_nxt_s = 1'b1;
        end else begin
          pc_inc_nxt_s = 1'b0;
        end
      end
      ST_EXEC: begin
        flag_en_nxt_s = 1'b1;
        pc_inc_nxt_s  = 1'b1;
        imm_sel_nxt_s = (nxt_op_s != OP_RR);
        if (nxt_op_s == OP_CMPI || (nxt_op_s == OP_RR && nxt_ext_s == EXT_CMP)) begin
          reg_en_nxt_s = {NUM_REGS{1'b0}};
        end else begin
          reg_en_nxt_s = onehot(nxt_rdest_s);
        end
      end
      ST_MEM_RD: addr_sel_nxt_s = 1'b1;
      ST_LOAD_WB: begin
        wb_sel_nxt_s = 1'b1;
        reg_en_nxt_s = onehot(nxt_rdest_s);
        pc_inc_nxt_s = 1'b1;
      end
      ST_MEM_WR: begin
        addr_sel_nxt_s = 1'b1;
        mem_we_nxt_s   = 1'b1;
        pc_inc_nxt_s   = 1'b1;
      end
      ST_BRANCH: begin
        if (cond_true(nxt_cond_s, flags)) begin
          pc_ld_nxt_s  = 1'b1;
          pc_src_nxt_s = (nxt_op_s == OP_BCOND);
        end else begin
          pc_inc_nxt_s = 1'b1;
        end
      end
      default: pc_inc_nxt_s = 1'b0;
    endcase
  end

  // State, instruction and output registers; reset clears every strobe at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_RESET;
      instr_r     <= {DATA_W{1'b0}};
      mux_a_sel_r <= {SEL_W{1'b0}};
      mux_b_sel_r <= {SEL_W{1'b0}};
      reg_en_r    <= {NUM_REGS{1'b0}};
      wb_sel_r    <= 1'b0;
      imm_sel_r   <= 1'b0;
      flag_en_r   <= 1'b0;
      addr_sel_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      pc_inc_r    <= 1'b0;
      pc_ld_r     <= 1'b0;
      pc_src_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      instr_r     <= instr_nxt_s;
      mux_a_sel_r <= instr_nxt_s[8 +: SEL_W];
      mux_b_sel_r <= instr_nxt_s[0 +: SEL_W];
      reg_en_r    <= reg_en_nxt_s;
      wb_sel_r    <= wb_sel_nxt_s;
      imm_sel_r   <= imm_sel_nxt_s;
      flag_en_r   <= flag_en_nxt_s;
      addr_sel_r  <= addr_sel_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      pc_inc_r    <= pc_inc_nxt_s;
      pc_ld_r     <= pc_ld_nxt_s;
      pc_src_r    <= pc_src_nxt_s;
    end
  end

  assign instr     = instr_r;
  assign mux_a_sel = mux_a_sel_r;
  assign mux_b_sel = mux_b_sel_r;
  assign reg_en    = reg_en_r;
  assign wb_sel    = wb_sel_r;
  assign imm_sel   = imm_sel_r;
  assign flag_en   = flag_en_r;
  assign addr_sel  = addr_sel_r;
  assign mem_we    = mem_we_r;
  assign pc_inc    = pc_inc_r;
  assign pc_ld     = pc_ld_r;
  assign pc_src    = pc_src_r;

endmodule
